// File: rtl/axi_io_bridge.sv
// -----------------------------------------------------------------------------
// axi_io_bridge
//
// Turns one line-level request from cache_core into a single AXI4 INCR burst
// (ID 0) on a 64-bit master port. Reads assemble the returned beats into a
// 512-bit line. Writes split the line into lane-aligned beats. Only one
// transaction is outstanding at a time.
//
// Optional build macro: YSYX210544_AXI_IO_ERR_EN
//    When it is defined, the output o_axi_io_err is added. It is a sticky OR of
//    any non-OKAY R or B response, shown together with o_axi_io_ready.
//
// Ports
//    clk, rst                 clock, asynchronous active-low reset
//    i_axi_io_valid/op/addr/wdata/size/blks
//                             line request, held until o_axi_io_ready
//    o_axi_io_ready           one-cycle completion pulse
//    o_axi_io_rdata           assembled read line, valid with ready
//    o_axi_io_err             (macro only) error flag, valid with ready
//    axi_aw_* / axi_w_* / axi_b_*   AXI write address / data / response
//    axi_ar_* / axi_r_*             AXI read address / data
// -----------------------------------------------------------------------------
module axi_io_bridge #(
   parameter int AXI_DATA_W = 64,
   parameter int LINE_W     = 512,
   parameter int ADDR_W     = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_axi_io_valid,
   input  logic                    i_axi_io_op,
   input  logic [ADDR_W-1:0]       i_axi_io_addr,
   input  logic [LINE_W-1:0]       i_axi_io_wdata,
   input  logic [1:0]              i_axi_io_size,
   input  logic [7:0]              i_axi_io_blks,
   output logic                    o_axi_io_ready,
   output logic [LINE_W-1:0]       o_axi_io_rdata,
`ifdef YSYX210544_AXI_IO_ERR_EN
   output logic                    o_axi_io_err,
`endif
   output logic                    axi_aw_valid,
   input  logic                    axi_aw_ready,
   output logic [ADDR_W-1:0]       axi_aw_addr,
   output logic [7:0]              axi_aw_len,
   output logic [2:0]              axi_aw_size,
   output logic [1:0]              axi_aw_burst,
   output logic                    axi_w_valid,
   input  logic                    axi_w_ready,
   output logic [AXI_DATA_W-1:0]   axi_w_data,
   output logic [AXI_DATA_W/8-1:0] axi_w_strb,
   output logic                    axi_w_last,
   input  logic                    axi_b_valid,
   input  logic [1:0]              axi_b_resp,
   output logic                    axi_b_ready,
   output logic                    axi_ar_valid,
   input  logic                    axi_ar_ready,
   output logic [ADDR_W-1:0]       axi_ar_addr,
   output logic [7:0]              axi_ar_len,
   output logic [2:0]              axi_ar_size,
   output logic [1:0]              axi_ar_burst,
   input  logic                    axi_r_valid,
   input  logic [AXI_DATA_W-1:0]   axi_r_data,
   input  logic [1:0]              axi_r_resp,
   input  logic                    axi_r_last,
   output logic                    axi_r_ready
);

   localparam int BEATS   = LINE_W / AXI_DATA_W;
   localparam int IDX_W   = $clog2(BEATS);
   localparam int CNT_W   = IDX_W + 1;
   localparam int LANE_SH = $clog2(AXI_DATA_W);
   localparam int STRB_W  = AXI_DATA_W / 8;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_AW   = 3'd3;
   localparam logic [2:0] S_W    = 3'd4;
   localparam logic [2:0] S_B    = 3'd5;
   localparam logic [2:0] S_DONE = 3'd6;

   // Byte-lane strobe for a narrow beat. A full-width beat always uses every
   // lane. A narrow beat uses the same lanes on every beat, selected by the
   // start offset.
   function automatic logic [STRB_W-1:0] strb_calc(input logic [1:0] size,
                                                   input logic [2:0] off);
      logic [15:0] m;
      case (size)
         2'd0:    m = 16'h0001;
         2'd1:    m = 16'h0003;
         2'd2:    m = 16'h000F;
         default: m = 16'h00FF;
      endcase
      if (size == 2'd3) begin
         m = 16'h00FF;
      end else begin
         m = m << off;
      end
      return m[STRB_W-1:0];
   endfunction

   logic [2:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      len_q;
   logic [LINE_W-1:0]     wdata_q;
   logic [LINE_W-1:0]     rdata_q;
   logic                  io_ready_q;
   logic                  ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;
   logic [ADDR_W-1:0]     ar_addr_q, aw_addr_q;
   logic [7:0]            ar_len_q, aw_len_q;
   logic [2:0]            ar_size_q, aw_size_q;
   logic [1:0]            ar_burst_q, aw_burst_q;
   logic [AXI_DATA_W-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;
   logic                  w_last_q;

   logic                  cap_s;
   logic [IDX_W-1:0]      len_cap_s;
   logic                  r_hs_s, w_hs_s, b_hs_s;
   logic [$clog2(LINE_W)-1:0] r_off_s, w_off_s;

   assign cap_s     = (state_q == S_IDLE) && i_axi_io_valid;
   assign len_cap_s = (i_axi_io_blks > 8'd7) ? 3'd7 : i_axi_io_blks[IDX_W-1:0];
   assign r_hs_s    = r_ready_q && axi_r_valid;
   assign w_hs_s    = w_valid_q && axi_w_ready;
   assign b_hs_s    = b_ready_q && axi_b_valid;
   // Bit offset of a beat inside the line.
   assign r_off_s   = {cnt_q[IDX_W-1:0], {LANE_SH{1'b0}}};
   assign w_off_s   = {cnt_d[IDX_W-1:0], {LANE_SH{1'b0}}};

   // Next-state and beat-counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (i_axi_io_valid) begin
               state_d = i_axi_io_op ? S_AW : S_AR;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_AR: begin
            if (ar_valid_q && axi_ar_ready) begin
               state_d = S_R;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = S_AR;
            end
         end
         S_R: begin
            if (r_hs_s) begin
               // The counter saturates at BEATS, so extra beats are dropped.
               // The burst ends on r_last and not on the count.
               if (!cnt_q[CNT_W-1]) begin
                  cnt_d = cnt_q + 4'd1;
               end else begin
                  cnt_d = cnt_q;
               end
               state_d = axi_r_last ? S_DONE : S_R;
            end else begin
               state_d = S_R;
            end
         end
         S_AW: begin
            if (aw_valid_q && axi_aw_ready) begin
               state_d = S_W;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = S_AW;
            end
         end
         S_W: begin
            if (w_hs_s) begin
               if (cnt_q[IDX_W-1:0] == len_q) begin
                  state_d = S_B;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else begin
               state_d = S_W;
            end
         end
         S_B: begin
            if (b_hs_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_B;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, captured request and registered AXI/requester outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         len_q      <= {IDX_W{1'b0}};
         wdata_q    <= {LINE_W{1'b0}};
         rdata_q    <= {LINE_W{1'b0}};
         io_ready_q <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_addr_q  <= {ADDR_W{1'b0}};
         aw_addr_q  <= {ADDR_W{1'b0}};
         ar_len_q   <= 8'd0;
         aw_len_q   <= 8'd0;
         ar_size_q  <= 3'd0;
         aw_size_q  <= 3'd0;
         ar_burst_q <= 2'b00;
         aw_burst_q <= 2'b00;
         w_data_q   <= {AXI_DATA_W{1'b0}};
         w_strb_q   <= {STRB_W{1'b0}};
         w_last_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;

         if (cap_s) begin
            len_q   <= len_cap_s;
            wdata_q <= i_axi_io_wdata;
            if (!i_axi_io_op) begin
               rdata_q    <= {LINE_W{1'b0}};
               ar_addr_q  <= i_axi_io_addr;
               ar_len_q   <= {5'd0, len_cap_s};
               ar_size_q  <= {1'b0, i_axi_io_size};
               ar_burst_q <= 2'b01;
            end else begin
               aw_addr_q  <= i_axi_io_addr;
               aw_len_q   <= {5'd0, len_cap_s};
               aw_size_q  <= {1'b0, i_axi_io_size};
               aw_burst_q <= 2'b01;
               w_strb_q   <= strb_calc(i_axi_io_size, i_axi_io_addr[2:0]);
            end
         end else if (r_hs_s && !cnt_q[CNT_W-1]) begin
            rdata_q[r_off_s +: AXI_DATA_W] <= axi_r_data;
         end else begin
            rdata_q <= rdata_q;
         end

         // The valid/ready flags follow the next state, so each one is a
         // flop that rises on the same edge the state is entered.
         ar_valid_q <= (state_d == S_AR);
         r_ready_q  <= (state_d == S_R);
         aw_valid_q <= (state_d == S_AW);
         w_valid_q  <= (state_d == S_W);
         b_ready_q  <= (state_d == S_B);
         io_ready_q <= (state_d == S_DONE);

         if (state_d == S_W) begin
            w_data_q <= wdata_q[w_off_s +: AXI_DATA_W];
            w_last_q <= (cnt_d == {1'b0, len_q});
         end else begin
            w_data_q <= w_data_q;
            w_last_q <= 1'b0;
         end
      end
   end

`ifdef YSYX210544_AXI_IO_ERR_EN
   logic err_q;

   // Sticky response-error flag, cleared when a new request is captured.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (cap_s) begin
         err_q <= 1'b0;
      end else if ((r_hs_s && (axi_r_resp != 2'b00)) || (b_hs_s && (axi_b_resp != 2'b00))) begin
         err_q <= 1'b1;
      end else begin
         err_q <= err_q;
      end
   end

   assign o_axi_io_err = err_q;
`else
   logic unused_resp_s;
   assign unused_resp_s = ^{axi_r_resp, axi_b_resp};
`endif

   assign o_axi_io_ready = io_ready_q;
   assign o_axi_io_rdata = rdata_q;
   assign axi_ar_valid   = ar_valid_q;
   assign axi_ar_addr    = ar_addr_q;
   assign axi_ar_len     = ar_len_q;
   assign axi_ar_size    = ar_size_q;
   assign axi_ar_burst   = ar_burst_q;
   assign axi_r_ready    = r_ready_q;
   assign axi_aw_valid   = aw_valid_q;
   assign axi_aw_addr    = aw_addr_q;
   assign axi_aw_len     = aw_len_q;
   assign axi_aw_size    = aw_size_q;
   assign axi_aw_burst   = aw_burst_q;
   assign axi_w_valid    = w_valid_q;
   assign axi_w_data     = w_data_q;
   assign axi_w_strb     = w_strb_q;
   assign axi_w_last     = w_last_q;
   assign axi_b_ready    = b_ready_q;

endmodule

// File: tb/tb_axi_io_bridge.sv
module tb_axi_io_bridge;

   typedef logic [72:0] wbeat_t;   // {data, strb, last}

   logic         clk;
   logic         rst;
   logic         i_axi_io_valid, i_axi_io_op;
   logic [63:0]  i_axi_io_addr;
   logic [511:0] i_axi_io_wdata;
   logic [1:0]   i_axi_io_size;
   logic [7:0]   i_axi_io_blks;
   logic         o_axi_io_ready;
   logic [511:0] o_axi_io_rdata;
`ifdef YSYX210544_AXI_IO_ERR_EN
   logic         o_axi_io_err;
`endif
   logic         axi_aw_valid, axi_aw_ready;
   logic [63:0]  axi_aw_addr;
   logic [7:0]   axi_aw_len;
   logic [2:0]   axi_aw_size;
   logic [1:0]   axi_aw_burst;
   logic         axi_w_valid, axi_w_ready, axi_w_last;
   logic [63:0]  axi_w_data;
   logic [7:0]   axi_w_strb;
   logic         axi_b_valid, axi_b_ready;
   logic [1:0]   axi_b_resp;
   logic         axi_ar_valid, axi_ar_ready;
   logic [63:0]  axi_ar_addr;
   logic [7:0]   axi_ar_len;
   logic [2:0]   axi_ar_size;
   logic [1:0]   axi_ar_burst;
   logic         axi_r_valid, axi_r_ready, axi_r_last;
   logic [63:0]  axi_r_data;
   logic [1:0]   axi_r_resp;

   int checks;
   int failures;

   // Observations collected by the slave model.
   int           ready_cnt;
   int           ready_cyc;
   int           unstable;
   bit           timeout;
   logic [511:0] rdata_obs;
   logic         err_obs;
   logic [63:0]  ax_addr;
   logic [7:0]   ax_len;
   logic [2:0]   ax_size;
   logic [1:0]   ax_burst;
   logic [63:0]  r_seed;
   logic [1:0]   b_err;

   // Scoreboard queues.
   wbeat_t       exp_w[$];
   wbeat_t       obs_w[$];
   logic [511:0] exp_rdata[$];

   axi_io_bridge dut (
      .clk(clk), .rst(rst),
      .i_axi_io_valid(i_axi_io_valid), .i_axi_io_op(i_axi_io_op),
      .i_axi_io_addr(i_axi_io_addr), .i_axi_io_wdata(i_axi_io_wdata),
      .i_axi_io_size(i_axi_io_size), .i_axi_io_blks(i_axi_io_blks),
      .o_axi_io_ready(o_axi_io_ready), .o_axi_io_rdata(o_axi_io_rdata),
`ifdef YSYX210544_AXI_IO_ERR_EN
      .o_axi_io_err(o_axi_io_err),
`endif
      .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_addr(axi_aw_addr),
      .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst),
      .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
      .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
      .axi_b_valid(axi_b_valid), .axi_b_resp(axi_b_resp), .axi_b_ready(axi_b_ready),
      .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
      .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst),
      .axi_r_valid(axi_r_valid), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
      .axi_r_last(axi_r_last), .axi_r_ready(axi_r_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] beat_val(input logic [63:0] seed, input int k);
      logic [63:0] m;
      m = 64'(k + 1);
      return (64'h1111_1111_1111_1111 * m) ^ seed;
   endfunction

   function automatic logic [511:0] exp_line(input logic [63:0] seed);
      logic [511:0] l;
      for (int k = 0; k < 8; k++) l[64*k +: 64] = beat_val(seed, k);
      return l;
   endfunction

   function automatic logic [511:0] wr_line();
      logic [511:0] l;
      for (int k = 0; k < 8; k++) l[64*k +: 64] = 64'h0123_4567_0000_0000 | 64'(k);
      return l;
   endfunction

   // Slave model and requester for one transaction. It only collects
   // observations, and the test tasks compare them.
   task automatic run_txn(input logic op, input logic [63:0] addr, input logic [511:0] wd,
                          input logic [1:0] size, input logic [7:0] blks, input int nbeats,
                          input int err_beat, input int aw_stall, input bit w_toggle,
                          input int abort_after);
      int k, stall_seen, post;
      bit ax_done, w_done, b_done, aw_stl, w_stl;
      logic [63:0] paddr;
      logic [72:0] pw;
      k = 0; stall_seen = 0; post = -1;
      ax_done = 0; w_done = 0; b_done = 0; aw_stl = 0; w_stl = 0;
      paddr = '0; pw = '0;
      ready_cnt = 0; ready_cyc = -1; unstable = 0; timeout = 1'b1;
      rdata_obs = '0; err_obs = 1'b0;
      ax_addr = '0; ax_len = '0; ax_size = '0; ax_burst = '0;
      obs_w.delete();
      i_axi_io_valid = 1'b1; i_axi_io_op = op; i_axi_io_addr = addr;
      i_axi_io_wdata = wd; i_axi_io_size = size; i_axi_io_blks = blks;
      axi_ar_ready = 1'b1; axi_aw_ready = (aw_stall == 0); axi_w_ready = 1'b1;
      axi_r_valid = 1'b0; axi_b_valid = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (o_axi_io_ready) begin
            ready_cnt++;
            if (ready_cyc < 0) ready_cyc = cyc;
            rdata_obs = o_axi_io_rdata;
`ifdef YSYX210544_AXI_IO_ERR_EN
            err_obs = o_axi_io_err;
`endif
            i_axi_io_valid = 1'b0;
            if (post < 0) post = 3;
            timeout = 1'b0;
         end
         if (axi_ar_valid && axi_ar_ready) begin
            ax_addr = axi_ar_addr; ax_len = axi_ar_len; ax_size = axi_ar_size;
            ax_burst = axi_ar_burst; ax_done = 1;
         end
         if (axi_aw_valid) begin
            if (aw_stl && axi_aw_addr !== paddr) unstable++;
            paddr = axi_aw_addr;
            aw_stl = !axi_aw_ready;
            if (axi_aw_ready) begin
               ax_addr = axi_aw_addr; ax_len = axi_aw_len; ax_size = axi_aw_size;
               ax_burst = axi_aw_burst; ax_done = 1;
            end else begin
               stall_seen++;
            end
         end
         if (axi_w_valid) begin
            if (w_stl && {axi_w_data, axi_w_strb, axi_w_last} !== pw) unstable++;
            pw = {axi_w_data, axi_w_strb, axi_w_last};
            w_stl = !axi_w_ready;
            if (axi_w_ready) begin
               obs_w.push_back(pw);
               if (axi_w_last) w_done = 1;
            end
         end
         if (axi_r_valid && axi_r_ready) k++;
         if (axi_b_valid && axi_b_ready) b_done = 1;
         @(posedge clk); #1;
         if (abort_after > 0 && k == abort_after) begin
            timeout = 1'b0;
            break;
         end
         if (post == 0) break;
         if (post > 0) post--;
         axi_aw_ready = (stall_seen >= aw_stall);
         axi_w_ready  = w_toggle ? ~axi_w_ready : 1'b1;
         axi_r_valid  = ax_done && !op && (k < nbeats);
         axi_r_data   = beat_val(r_seed, k);
         axi_r_resp   = (k == err_beat) ? 2'd2 : 2'd0;
         axi_r_last   = (k == nbeats - 1);
         axi_b_valid  = w_done && !b_done;
         axi_b_resp   = b_err;
      end
      i_axi_io_valid = 1'b0; axi_r_valid = 1'b0; axi_b_valid = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (o_axi_io_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", o_axi_io_ready); end
      checks++; if (o_axi_io_rdata !== 512'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", o_axi_io_rdata); end
      checks++;
      if ({axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready} !== 5'd0) begin
         failures++; $display("FAIL reset_handshake got=%b exp=00000",
                              {axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready});
      end
      checks++;
      if ({axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_aw_addr, axi_aw_len, axi_aw_size, axi_aw_burst} !== '0) begin
         failures++; $display("FAIL reset_addr_fields got=%h/%h exp=0", axi_ar_addr, axi_aw_addr);
      end
   endtask

   task automatic test_read();
      r_seed = 64'd0;
      exp_rdata.push_back(exp_line(r_seed));
      run_txn(1'b0, 64'h8000_0000, '0, 2'd3, 8'd7, 8, -1, 0, 1'b0, 0);
      checks++; if (timeout) begin failures++; $display("FAIL read_timeout got=no_ready exp=ready"); end
      checks++; if (ax_addr !== 64'h8000_0000) begin failures++; $display("FAIL read_ar_addr got=%h exp=80000000", ax_addr); end
      checks++; if ({ax_len, ax_size, ax_burst} !== {8'd7, 3'd3, 2'd1}) begin failures++; $display("FAIL read_ar_fields got=%0d/%0d/%0d exp=7/3/1", ax_len, ax_size, ax_burst); end
      checks++; if (ready_cnt !== 1) begin failures++; $display("FAIL read_ready_pulses got=%0d exp=1", ready_cnt); end
      checks++; if (ready_cyc !== 10) begin failures++; $display("FAIL read_latency got=%0d exp=10", ready_cyc); end
      checks++;
      if (rdata_obs !== exp_rdata.pop_front()) begin failures++; $display("FAIL read_rdata got=%h", rdata_obs); end
   endtask

   task automatic test_write();
      logic [511:0] wd;
      wbeat_t e, o;
      wd = wr_line();
      for (int k = 0; k < 8; k++) exp_w.push_back({wd[64*k +: 64], 8'hFF, (k == 7)});
      b_err = 2'd0;
      run_txn(1'b1, 64'h8000_1000, wd, 2'd3, 8'd7, 0, -1, 0, 1'b0, 0);
      checks++; if (timeout) begin failures++; $display("FAIL write_timeout got=no_ready exp=ready"); end
      checks++; if ({ax_addr, ax_len, ax_size, ax_burst} !== {64'h8000_1000, 8'd7, 3'd3, 2'd1}) begin failures++; $display("FAIL write_aw_fields got=%h/%0d/%0d/%0d", ax_addr, ax_len, ax_size, ax_burst); end
      checks++; if (obs_w.size() !== exp_w.size()) begin failures++; $display("FAIL write_beats got=%0d exp=%0d", obs_w.size(), exp_w.size()); end
      while (exp_w.size() > 0 && obs_w.size() > 0) begin
         e = exp_w.pop_front(); o = obs_w.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL write_beat got=%h exp=%h", o, e); end
      end
      exp_w.delete();
      checks++; if (ready_cnt !== 1) begin failures++; $display("FAIL write_ready_pulses got=%0d exp=1", ready_cnt); end
      checks++; if (ready_cyc !== 11) begin failures++; $display("FAIL write_latency got=%0d exp=11", ready_cyc); end
   endtask

   task automatic test_narrow_write();
      logic [511:0] wd;
      wbeat_t e, o;
      wd = wr_line() ^ {8{64'hA5A5_0000_0000_005A}};
      exp_w.push_back({wd[63:0], 8'h08, 1'b1});
      run_txn(1'b1, 64'h8000_0003, wd, 2'd0, 8'd0, 0, -1, 0, 1'b0, 0);
      checks++; if ({ax_len, ax_size} !== {8'd0, 3'd0}) begin failures++; $display("FAIL narrow_aw got=%0d/%0d exp=0/0", ax_len, ax_size); end
      checks++; if (obs_w.size() !== 1) begin failures++; $display("FAIL narrow_beats got=%0d exp=1", obs_w.size()); end
      while (exp_w.size() > 0 && obs_w.size() > 0) begin
         e = exp_w.pop_front(); o = obs_w.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL narrow_beat got=%h exp=%h", o, e); end
      end
      exp_w.delete();
      checks++; if (ready_cnt !== 1) begin failures++; $display("FAIL narrow_ready_pulses got=%0d exp=1", ready_cnt); end
   endtask

   task automatic test_backpressure();
      logic [511:0] wd;
      wbeat_t e, o;
      for (int k = 0; k < 8; k++) wd[64*k +: 64] = 64'hBEEF_0000_0000_0000 | 64'(k * 3 + 1);
      for (int k = 0; k < 8; k++) exp_w.push_back({wd[64*k +: 64], 8'hFF, (k == 7)});
      run_txn(1'b1, 64'h8000_2000, wd, 2'd3, 8'd7, 0, -1, 5, 1'b1, 0);
      checks++; if (timeout) begin failures++; $display("FAIL bp_timeout got=no_ready exp=ready"); end
      checks++; if (unstable !== 0) begin failures++; $display("FAIL bp_stable got=%0d changes exp=0", unstable); end
      checks++; if (obs_w.size() !== 8) begin failures++; $display("FAIL bp_beats got=%0d exp=8", obs_w.size()); end
      while (exp_w.size() > 0 && obs_w.size() > 0) begin
         e = exp_w.pop_front(); o = obs_w.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL bp_beat got=%h exp=%h", o, e); end
      end
      exp_w.delete();
      checks++; if (ready_cnt !== 1) begin failures++; $display("FAIL bp_ready_pulses got=%0d exp=1", ready_cnt); end
   endtask

   task automatic test_clamp();
      // blks above 7 is clamped, and beats past the eighth are dropped.
      r_seed = 64'h0F0F_0000_F0F0_0000;
      exp_rdata.push_back(exp_line(r_seed));
      run_txn(1'b0, 64'h8000_0200, '0, 2'd3, 8'd20, 10, -1, 0, 1'b0, 0);
      checks++; if (ax_len !== 8'd7) begin failures++; $display("FAIL clamp_ar_len got=%0d exp=7", ax_len); end
      checks++; if (ready_cnt !== 1) begin failures++; $display("FAIL clamp_ready_pulses got=%0d exp=1", ready_cnt); end
      checks++;
      if (rdata_obs !== exp_rdata.pop_front()) begin failures++; $display("FAIL clamp_rdata got=%h", rdata_obs); end
   endtask

   task automatic test_reset_mid();
      int rc;
      r_seed = 64'h5555_0000_0000_AAAA;
      run_txn(1'b0, 64'h8000_0000, '0, 2'd3, 8'd7, 8, -1, 0, 1'b0, 3);
      rst = 1'b0;
      #1;
      checks++; if ({axi_r_ready, axi_ar_valid, o_axi_io_ready} !== 3'b000) begin failures++; $display("FAIL rstmid_outputs got=%b exp=000", {axi_r_ready, axi_ar_valid, o_axi_io_ready}); end
      rc = 0;
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (o_axi_io_ready) rc++; end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (o_axi_io_ready) rc++; end
      checks++; if (rc !== 0) begin failures++; $display("FAIL rstmid_no_ready got=%0d exp=0", rc); end
      @(posedge clk); #1;
      r_seed = 64'h0000_7777_0000_3333;
      exp_rdata.push_back(exp_line(r_seed));
      run_txn(1'b0, 64'h8000_0040, '0, 2'd3, 8'd7, 8, -1, 0, 1'b0, 0);
      checks++; if (ax_addr !== 64'h8000_0040) begin failures++; $display("FAIL rstmid_ar_addr got=%h exp=80000040", ax_addr); end
      checks++; if (ready_cnt !== 1) begin failures++; $display("FAIL rstmid_ready_pulses got=%0d exp=1", ready_cnt); end
      checks++;
      if (rdata_obs !== exp_rdata.pop_front()) begin failures++; $display("FAIL rstmid_rdata got=%h", rdata_obs); end
   endtask

`ifdef YSYX210544_AXI_IO_ERR_EN
   task automatic test_err();
      r_seed = 64'd0;
      run_txn(1'b0, 64'h8000_0000, '0, 2'd3, 8'd7, 8, 3, 0, 1'b0, 0);
      checks++; if (err_obs !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err_obs); end
      run_txn(1'b0, 64'h8000_0000, '0, 2'd3, 8'd7, 8, -1, 0, 1'b0, 0);
      checks++; if (err_obs !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err_obs); end
   endtask
`endif

   initial begin
      checks = 0; failures = 0;
      rst = 1'b0; r_seed = '0; b_err = 2'd0;
      i_axi_io_valid = 1'b0; i_axi_io_op = 1'b0; i_axi_io_addr = '0; i_axi_io_wdata = '0;
      i_axi_io_size = '0; i_axi_io_blks = '0;
      axi_aw_ready = 1'b0; axi_w_ready = 1'b0; axi_b_valid = 1'b0; axi_b_resp = '0;
      axi_ar_ready = 1'b0; axi_r_valid = 1'b0; axi_r_data = '0; axi_r_resp = '0; axi_r_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      test_read();
      test_write();
      test_narrow_write();
      test_backpressure();
      test_clamp();
      test_reset_mid();
`ifdef YSYX210544_AXI_IO_ERR_EN
      test_err();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
